im_port_arbiter: RTL
====================

// Module: im_port_arbiter
// PURPOSE
//  Shares the single-port synchronous instruction RAM (4096 x 32, base 0x0000_3000) between the CPU
//  fetch stage and the boot/debug loader. Translates byte addresses to word indices, range/alignment
//  checks every access, grants one access per cycle, and returns each response exactly one cycle later.
//  A boot lock gives the loader exclusive use of the RAM while an image is loaded.
// PARAMETERS
//  BASE_ADDR   32'h0000_3000  byte address of RAM word 0
//  AW          12             word-index width; the RAM holds 2**AW words
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  f_req       in   1   fetch request; held with f_addr stable until f_gnt
//  f_addr      in   32  fetch byte address
//  f_gnt       out  1   fetch accepted this cycle (combinational)
//  f_rvalid    out  1   fetch response valid (one cycle after f_gnt)
//  f_rdata     out  32  fetched instruction; 0 (NOP) when f_err
//  f_err       out  1   address error on this response (qualified by f_rvalid)
//  ld_lock     in   1   boot lock request; loader gets exclusive RAM access
//  ld_req      in   1   loader request; held with address, write enable and data stable until ld_gnt
//  ld_we       in   1   1 = write, 0 = read
//  ld_addr     in   32  loader byte address
//  ld_wdata    in   32  loader write data
//  ld_gnt      out  1   loader accepted this cycle (combinational)
//  ld_rvalid   out  1   loader response / write acknowledge
//  ld_rdata    out  32  read data; 0 for writes and errors
//  ld_err      out  1   address error (qualified by ld_rvalid)
//  booting     out  1   FSM is in BOOT
//  wr_count    out  AW+1  words written since BOOT entry (saturates at 2**AW)
//  mem_en      out  1   RAM enable
//  mem_we      out  1   RAM write enable
//  mem_addr    out  AW  RAM word index
//  mem_wdata   out  32  RAM write data
//  mem_rdata   in   32  RAM read data, valid the cycle after mem_en
// BEHAVIOUR
//  Reset values: all outputs 0, FSM = RUN, rr_last = LD (fetch wins the first tie).
//  Address check: off = addr - BASE_ADDR. The access is legal iff addr[1:0] == 0 and off < 4*2**AW.
//   mem_addr = off[AW+1:2].
//  Illegal access: it is still granted, but mem_en stays 0. The next cycle gives rvalid = 1, err = 1,
//   rdata = 0.
//  Grant: at most one gnt per cycle; the same-cycle gnt drives mem_en / mem_we / mem_addr / mem_wdata.
//  Response: rvalid exactly 1 cycle after gnt, to the granted requester only. Read data is mem_rdata.
//   A write returns an acknowledge with rdata = 0. No back-pressure: responses must be accepted.
//  FSM RUN: both requesting -> round-robin on rr_last; a single requester always wins.
//   Go to BOOT when ld_lock = 1.
//  FSM BOOT: f_gnt is forced to 0 and the loader is granted every cycle it requests.
//   Go to RUN when ld_lock = 0; the in-flight response completes normally.
//  wr_count: cleared on the RUN->BOOT transition. Increments on each granted legal write in BOOT.
//  Simultaneous events: ld_lock rising while f_req is high blocks fetch that same cycle (lock wins).
//   A response from the previous cycle is still delivered in the cycle the lock rises.
//  Reset mid-operation: a pending response is dropped (rvalid stays 0) and the FSM returns to RUN.
//  rr_last updates only on a grant made while both requesters are requesting.
// STRUCTURE
//  im_pkg: BASE_ADDR and AW defaults, the owner enum {OWN_NONE, OWN_F, OWN_LD},
//   the FSM state enum {ST_RUN, ST_BOOT}, and an addr_ok() check function.
//  Sub-module im_rr_arb2: 2-way round-robin arbiter (req[1:0], en, gnt[1:0]); holds rr_last internally.
//  Top level: address decode, FSM, response register (owner, err), wr_count.
// TESTING
//  1 f_req with f_addr = 0x3004, RAM word 1 = 0x2408_0005 -> f_gnt same cycle, mem_addr = 1;
//    next cycle f_rvalid = 1, f_rdata = 0x2408_0005, f_err = 0.
//  2 f_addr = 0x2FFC, then 0x7000, then 0x3002 -> each is granted with mem_en = 0;
//    next cycle f_rvalid = 1, f_err = 1, f_rdata = 0.
//  3 f_req and ld_req both high for 4 cycles -> grants alternate F, LD, F, LD;
//    each rvalid goes to the matching owner.
//  4 ld_lock = 1 with fetch requesting; loader writes 0xDEAD_BEEF to 0x4180
//    -> f_gnt = 0 throughout, mem_addr = 0x460, wr_count = 1.
//    ld_lock = 0 -> fetch of 0x4180 returns 0xDEAD_BEEF.
//  5 Assert reset the cycle after a fetch grant -> no f_rvalid; booting = 0;
//    the first grant after release goes to fetch.
//  6 Random traffic for 10k cycles against a reference memory model -> every gnt gives exactly one rvalid;
//    data and err match the model; never two gnts in one cycle.

Source files
------------

// File: rtl/im_port_arbiter_pkg.sv
// Shared definitions for the instruction-RAM port arbiter: default geometry,
// response owner and FSM state encodings, and the address legality check.
package im_pkg;

    localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
    localparam int unsigned IM_AW        = 12;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BOOT = 1'b1
    } state_e;

    // Word-aligned and inside the 2**aw-word window starting at base.
    // The offset is widened so a window reaching the top of the map still compares correctly.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned aw);
        logic [32:0] off_s;
        logic [32:0] lim_s;
        off_s = {1'b0, addr - base};
        lim_s = 33'd4 << aw;
        return (addr[1:0] == 2'b00) && (off_s < lim_s);
    endfunction

endpackage

// File: rtl/im_port_arbiter_if.sv
// Bundle of the fetch port, loader port, status and RAM-side signals of the arbiter.
interface im_port_arbiter_if #(
    parameter int unsigned AW = 12
);

    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [31:0]   f_rdata;
    logic          f_err;

    logic          ld_lock;
    logic          ld_req;
    logic          ld_we;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [31:0]   ld_rdata;
    logic          ld_err;

    logic          booting;
    logic [AW:0]   wr_count;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata, f_err,
        input  ld_lock, ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata, ld_err,
        output booting, wr_count,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        output ld_lock, ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
        input  booting, wr_count,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/im_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is fetch, bit 1 is the loader; only a tie
// moves the priority pointer, and after reset fetch wins the first tie.
module im_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr_last_q;
    logic rr_last_d;

    // Grant selection and pointer update; rr_last_q = 1 means the loader won the last tie
    always_comb begin
        gnt       = 2'b00;
        rr_last_d = rr_last_q;
        if (en) begin
            case (req)
                2'b01: gnt = 2'b01;
                2'b10: gnt = 2'b10;
                2'b11: begin
                    if (rr_last_q) begin
                        gnt       = 2'b01;
                        rr_last_d = 1'b0;
                    end else begin
                        gnt       = 2'b10;
                        rr_last_d = 1'b1;
                    end
                end
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

    // Priority pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/im_port_arbiter.sv
// Shares the single-port instruction RAM between CPU fetch and the boot/debug loader,
// with a boot lock that hands the loader exclusive access while an image is loaded.
module im_port_arbiter
    import im_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = IM_BASE_ADDR,
    parameter int unsigned AW        = IM_AW
) (
    input  logic             clk,
    input  logic             reset,
    im_port_arbiter_if.slave bus
);

    localparam logic [AW:0] WR_MAX = {1'b1, {AW{1'b0}}};

    state_e        state_q,    state_d;
    owner_e        owner_q,    owner_d;
    logic          err_q,      err_d;
    logic          we_q,       we_d;
    logic [AW:0]   wr_count_q, wr_count_d;

    logic          f_ok_s;
    logic          ld_ok_s;
    logic [AW-1:0] f_idx_s;
    logic [AW-1:0] ld_idx_s;
    logic          lock_s;
    logic [1:0]    req_s;
    logic [1:0]    gnt_s;

    assign f_ok_s   = addr_ok(bus.f_addr,  BASE_ADDR, AW);
    assign ld_ok_s  = addr_ok(bus.ld_addr, BASE_ADDR, AW);
    assign f_idx_s  = AW'((bus.f_addr  - BASE_ADDR) >> 2);
    assign ld_idx_s = AW'((bus.ld_addr - BASE_ADDR) >> 2);

    // A lock request blocks fetch in the very cycle it rises, not only once BOOT is entered.
    // Masking fetch here also keeps boot traffic from moving the round-robin pointer.
    assign lock_s = (state_q == ST_BOOT) || bus.ld_lock;
    assign req_s  = {bus.ld_req, bus.f_req & ~lock_s};

    im_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_s),
        .en    (~reset),
        .gnt   (gnt_s)
    );

    // Grant outputs and RAM command for the access granted this cycle
    always_comb begin
        bus.f_gnt     = gnt_s[0];
        bus.ld_gnt    = gnt_s[1];
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0000_0000;
        if (gnt_s[0]) begin
            bus.mem_en   = f_ok_s;
            bus.mem_addr = f_idx_s;
        end else if (gnt_s[1]) begin
            bus.mem_en    = ld_ok_s;
            bus.mem_we    = ld_ok_s & bus.ld_we;
            bus.mem_addr  = ld_idx_s;
            bus.mem_wdata = bus.ld_we ? bus.ld_wdata : 32'h0000_0000;
        end else begin
            bus.mem_en = 1'b0;
        end
    end

    // What the next cycle's response must report
    always_comb begin
        owner_d = OWN_NONE;
        err_d   = 1'b0;
        we_d    = 1'b0;
        if (gnt_s[0]) begin
            owner_d = OWN_F;
            err_d   = ~f_ok_s;
        end else if (gnt_s[1]) begin
            owner_d = OWN_LD;
            err_d   = ~ld_ok_s;
            we_d    = bus.ld_we;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Response steering: RAM data passes only for a legal read; errors and write acks return 0
    always_comb begin
        bus.f_rvalid  = (owner_q == OWN_F);
        bus.f_err     = (owner_q == OWN_F) & err_q;
        bus.f_rdata   = 32'h0000_0000;
        bus.ld_rvalid = (owner_q == OWN_LD);
        bus.ld_err    = (owner_q == OWN_LD) & err_q;
        bus.ld_rdata  = 32'h0000_0000;
        if ((owner_q == OWN_F) && !err_q) begin
            bus.f_rdata = bus.mem_rdata;
        end else if ((owner_q == OWN_LD) && !err_q && !we_q) begin
            bus.ld_rdata = bus.mem_rdata;
        end else begin
            bus.f_rdata = 32'h0000_0000;
        end
    end

    // Boot FSM and the saturating count of legal words written during BOOT
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        case (state_q)
            ST_RUN: begin
                if (bus.ld_lock) begin
                    state_d    = ST_BOOT;
                    wr_count_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_BOOT: begin
                if (!bus.ld_lock) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_BOOT;
                end
                if (gnt_s[1] && bus.ld_we && ld_ok_s && (wr_count_q != WR_MAX)) begin
                    wr_count_d = wr_count_q + {{AW{1'b0}}, 1'b1};
                end else begin
                    wr_count_d = wr_count_q;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wr_count_d = '0;
            end
        endcase
    end

    // State, response and counter registers; reset drops any pending response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            owner_q    <= OWN_NONE;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            err_q      <= err_d;
            we_q       <= we_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.booting  = (state_q == ST_BOOT);
    assign bus.wr_count = wr_count_q;

endmodule
